// File: rtl/crc8_arbiter.sv
// crc8_arbiter: one bit-serial CRC8 engine shared round-robin among NREQ
// requesters. The grant stays with one requester for its whole message.
module crc8_arbiter #(
  parameter int         NREQ = 4,
  parameter logic [7:0] POLY = 8'h9B,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   byte_ack,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        crc_out,
  output logic              busy
);

  localparam int unsigned NR = NREQ;
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      crc_out_q, crc_out_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            lst_q, lst_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gidx_q, gidx_d;
  logic [GW-1:0]   rr_q, rr_d;

  logic [GW-1:0]   sel;
  logic            found;
  logic [GW-1:0]   next_ptr;
  logic            fb;
  logic [7:0]      crc_step;

  // Round-robin pick, one CRC bit step and the pointer past the current owner.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!found && req[(32'(rr_q) + k) % NR]) begin
        sel   = GW'((32'(rr_q) + k) % NR);
        found = 1'b1;
      end
    end
    next_ptr = (gidx_q == GW'(NR - 1)) ? '0 : gidx_q + GW'(1);
    fb       = crc_q[7] ^ shreg_q[7];
    crc_step = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  // Next-state and registered-output logic of the arbitration/CRC FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    done_d    = '0;
    crc_out_d = crc_out_q;
    crc_d     = crc_q;
    shreg_d   = shreg_q;
    lst_d     = lst_q;
    bit_cnt_d = bit_cnt_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          gidx_d       = sel;
          crc_d        = INIT;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (req[gidx_q]) begin
          shreg_d         = data[8*gidx_q +: 8];
          lst_d           = last[gidx_q];
          bit_cnt_d       = '0;
          ack_d[gidx_q]   = 1'b1;
          state_d         = SHIFT;
        end else begin
          // Owner withdrew between bytes: drop the message silently.
          grant_d = '0;
          rr_d    = next_ptr;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        crc_d     = crc_step;
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (lst_q) begin
            crc_out_d      = crc_step;
            done_d[gidx_q] = 1'b1;
            grant_d        = '0;
            rr_d           = next_ptr;
            state_d        = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      crc_out_q <= '0;
      crc_q     <= '0;
      shreg_q   <= '0;
      lst_q     <= 1'b0;
      bit_cnt_q <= '0;
      gidx_q    <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      crc_out_q <= crc_out_d;
      crc_q     <= crc_d;
      shreg_q   <= shreg_d;
      lst_q     <= lst_d;
      bit_cnt_q <= bit_cnt_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
    end
  end

  assign grant    = grant_q;
  assign byte_ack = ack_q;
  assign done     = done_q;
  assign crc_out  = crc_out_q;
  assign busy     = |grant_q;

endmodule

// File: tb/tb_crc8_arbiter.sv
// Directed bench for crc8_arbiter with a message-level reference model.
module tb_crc8_arbiter;

  localparam int         NREQ = 4;
  localparam logic [7:0] POLY = 8'h9B;
  localparam logic [7:0] INIT = 8'h00;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   byte_ack;
  logic [NREQ-1:0]   done;
  logic [7:0]        crc_out;
  logic              busy;

  crc8_arbiter #(.NREQ(NREQ), .POLY(POLY), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
    .grant(grant), .byte_ack(byte_ack), .done(done),
    .crc_out(crc_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Whole-message CRC, byte-at-a-time MSB-first formulation.
  function automatic logic [7:0] crc_msg(input logic [7:0] q[$]);
    logic [7:0] c;
    c = INIT;
    foreach (q[j]) begin
      c = c ^ q[j];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  // Reference model: owner, cycles since grant (9 per byte), collected bytes.
  int              m_owner = -1;
  int              m_t = 0;
  int              m_ptr = 0;
  int              m_i;
  bit              m_lst = 1'b0;
  bit              mvalid = 1'b0;
  logic [7:0]      m_bytes[$];
  logic [NREQ-1:0] e_grant = '0, e_ack = '0, e_done = '0;
  logic [7:0]      e_crc = '0;

  always @(posedge clk) begin
    e_ack  = '0;
    e_done = '0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      e_crc   = '0;
      mvalid  = 1'b1;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        m_i = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req[m_i]) m_owner = m_i;
      end
      m_t = 0;
      m_bytes.delete();
    end else if (m_t % 9 == 0) begin
      if (req[m_owner]) begin
        m_bytes.push_back(data[8*m_owner +: 8]);
        m_lst = last[m_owner];
        e_ack[m_owner] = 1'b1;
        m_t++;
      end else begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end else if (m_t % 9 == 8 && m_lst) begin
      e_crc = crc_msg(m_bytes);
      e_done[m_owner] = 1'b1;
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else begin
      m_t++;
    end
    e_grant = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("grant",    8'(grant),    8'(e_grant));
      chk("byte_ack", 8'(byte_ack), 8'(e_ack));
      chk("done",     8'(done),     8'(e_done));
      chk("crc_out",  crc_out,      e_crc);
      chk("busy",     8'(busy),     8'(e_grant != '0));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Runs one message of nb (1..2) bytes for requester idx; cycle offsets are
  // relative to the cycle in which req was raised. abort_mid drops req after
  // the first byte_ack and reports the cycle grant disappears in tend.
  task automatic run_msg(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                         input int nb, input bit abort_mid,
                         output int tg, output int ta0, output int ta1,
                         output int tend, output logic [7:0] crc);
    int c0, k;
    bit fin;
    tg = -1; ta0 = -1; ta1 = -1; tend = -1; crc = '0; k = 0; fin = 1'b0;
    c0 = cyc;
    data[8*idx +: 8] = b0;
    last[idx] = (nb == 1);
    req[idx]  = 1'b1;
    for (int n = 0; n < 60 && !fin; n++) begin
      tick();
      if (grant[idx] && tg < 0) tg = cyc - c0;
      if (byte_ack[idx]) begin
        if (k == 0) ta0 = cyc - c0; else ta1 = cyc - c0;
        k++;
        if (abort_mid) req[idx] = 1'b0;
        else if (k < nb) begin
          data[8*idx +: 8] = b1;
          last[idx] = (k == nb - 1);
        end
      end
      if (done[idx]) begin
        tend = cyc - c0;
        crc  = crc_out;
        req[idx] = 1'b0;
        fin = 1'b1;
      end
      if (abort_mid && k > 0 && !grant[idx] && !fin) begin
        tend = cyc - c0;
        fin = 1'b1;
      end
    end
    if (!fin) begin
      chk("msg_timeout", 8'(fin), 8'd1);
      req[idx] = 1'b0;
    end
  endtask

  int         tg, ta0, ta1, tend;
  logic [7:0] crc;
  int         seq[$];
  logic [NREQ-1:0] prevg;
  int         ndone;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    rst = 1'b1; req = '0; data = '0; last = '0;
    repeat (3) tick();
    chk("reset_grant", 8'(grant), 8'h00);
    chk("reset_busy",  8'(busy),  8'h00);
    rst = 1'b0;
    tick();

    // Single byte 0x01 from requester 0: timing and CRC.
    run_msg(0, 8'h01, 8'h00, 1, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t1_grant_lat", 8'(tg),   8'd1);
    chk("t1_ack_lat",   8'(ta0),  8'd2);
    chk("t1_done_lat",  8'(tend), 8'd10);
    chk("t1_crc",       crc,      8'h9B);
    tick();

    // Two-byte message 0x01,0x00 from requester 1.
    run_msg(1, 8'h01, 8'h00, 2, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t2_ack0_lat", 8'(ta0),  8'd2);
    chk("t2_ack1_lat", 8'(ta1),  8'd11);
    chk("t2_done_lat", 8'(tend), 8'd19);
    chk("t2_crc",      crc,      8'h16);
    tick();
    run_msg(2, 8'h80, 8'h00, 1, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t3_crc_80", crc, 8'h0B);
    tick();
    run_msg(3, 8'h00, 8'h00, 1, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t3_crc_00", crc, 8'h00);
    tick();

    // All four requesting single bytes continuously: rotation 0,1,2,3,0.
    data = {8'h01, 8'h00, 8'h80, 8'h01};
    last = '1;
    req  = '1;
    prevg = '0;
    seq.delete();
    for (int n = 0; n < 80 && seq.size() < 5; n++) begin
      tick();
      if (grant != '0 && grant != prevg) seq.push_back(onehot_idx(grant));
      prevg = grant;
    end
    req = '0;
    chk("rr_count", 8'(seq.size()), 8'd5);
    while (seq.size() < 5) seq.push_back(-1);
    chk("rr_0", 8'(seq[0]), 8'd0);
    chk("rr_1", 8'(seq[1]), 8'd1);
    chk("rr_2", 8'(seq[2]), 8'd2);
    chk("rr_3", 8'(seq[3]), 8'd3);
    chk("rr_4", 8'(seq[4]), 8'd0);
    last = '0;
    repeat (3) tick();

    // Requester 2 finishes, then 0 and 2 contend: scan wraps to 0 first.
    run_msg(2, 8'h01, 8'h00, 1, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t5_crc", crc, 8'h9B);
    tick();
    data[7:0] = 8'h01; data[23:16] = 8'h80;
    last = 4'b0101;
    req  = 4'b0101;
    seq.delete();
    prevg = '0;
    ndone = 0;
    for (int n = 0; n < 60 && ndone < 2; n++) begin
      tick();
      if (grant != '0 && grant != prevg) seq.push_back(onehot_idx(grant));
      prevg = grant;
      if (done != '0) begin
        ndone++;
        req = req & ~done;
      end
    end
    req = '0;
    last = '0;
    chk("t5_ndone", 8'(ndone), 8'd2);
    while (seq.size() < 2) seq.push_back(-1);
    chk("t5_first",  8'(seq[0]), 8'd0);
    chk("t5_second", 8'(seq[1]), 8'd2);
    chk("t5_crc_last", crc_out, 8'h0B);
    tick();

    // Requester 1 drops req between bytes: abort, CRC output untouched.
    run_msg(1, 8'h01, 8'h00, 2, 1'b1, tg, ta0, ta1, tend, crc);
    chk("t6_ack_lat",   8'(ta0),  8'd2);
    chk("t6_abort_lat", 8'(tend), 8'd11);
    chk("t6_done_none", 8'(done), 8'h00);
    chk("t6_crc_held",  crc_out,  8'h0B);
    run_msg(3, 8'h01, 8'h00, 1, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t6_next_grant", 8'(tg), 8'd1);
    chk("t6_next_crc",   crc,    8'h9B);
    tick();

    // Reset during SHIFT of requester 3.
    data[31:24] = 8'h80;
    last[3] = 1'b1;
    req[3]  = 1'b1;
    ndone = 0;
    for (int n = 0; n < 20 && ndone == 0; n++) begin
      tick();
      if (byte_ack[3]) ndone = 1;
    end
    chk("t7_ack_seen", 8'(ndone), 8'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t7_rst_grant", 8'(grant),    8'h00);
    chk("t7_rst_ack",   8'(byte_ack), 8'h00);
    chk("t7_rst_done",  8'(done),     8'h00);
    chk("t7_rst_crc",   crc_out,      8'h00);
    chk("t7_rst_busy",  8'(busy),     8'h00);
    rst = 1'b0;
    req = '0;
    last = '0;
    run_msg(0, 8'h80, 8'h00, 1, 1'b0, tg, ta0, ta1, tend, crc);
    chk("t7_restart_grant", 8'(tg), 8'd1);
    chk("t7_restart_crc",   crc,    8'h0B);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
